// File: rtl/guard_pipe.sv
`default_nettype none
// guard_pipe: ordered LT/GT/EQ guard of in_data against in_thresh through a two-stage
// elastic pipeline, with saturating per-class counts of delivered results. Rev 1.0
module guard_pipe #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1,
  parameter int RES_LT = 0,
  parameter int RES_GT = 1,
  parameter int RES_EQ = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_class,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_eq
);

  localparam logic [WIDTH-1:0] C_RES_LT = WIDTH'(RES_LT);
  localparam logic [WIDTH-1:0] C_RES_GT = WIDTH'(RES_GT);
  localparam logic [WIDTH-1:0] C_RES_EQ = WIDTH'(RES_EQ);
  localparam logic [1:0]       C_CLS_LT = 2'd0;
  localparam logic [1:0]       C_CLS_GT = 2'd1;
  localparam logic [1:0]       C_CLS_EQ = 2'd2;

  logic w_lt;
  logic w_gt;

  generate
    if (SIGNED) begin : g_signed
      assign w_lt = $signed(in_data) < $signed(in_thresh);
      assign w_gt = $signed(in_data) > $signed(in_thresh);
    end else begin : g_unsigned
      assign w_lt = in_data < in_thresh;
      assign w_gt = in_data > in_thresh;
    end
  endgenerate

  logic r_s1_valid;
  logic r_s1_lt;
  logic r_s1_gt;
  logic w_s2_ready;
  logic w_out_fire;

  assign w_s2_ready = !out_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_ready;
  assign w_out_fire = out_valid && out_ready;

  // S1: compare flags only; operands are not retained
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_lt    <= 1'b0;
      r_s1_gt    <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_lt <= w_lt;
        r_s1_gt <= w_gt;
      end
    end
  end

  logic [WIDTH-1:0] w_s2_data;
  logic [1:0]       w_s2_class;

  // LT is tested before GT; EQ is the fall-through branch
  always_comb begin
    w_s2_data  = C_RES_EQ;
    w_s2_class = C_CLS_EQ;
    if (r_s1_lt) begin
      w_s2_data  = C_RES_LT;
      w_s2_class = C_CLS_LT;
    end else if (r_s1_gt) begin
      w_s2_data  = C_RES_GT;
      w_s2_class = C_CLS_GT;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_class <= 2'd0;
    end else if (w_s2_ready) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_data  <= w_s2_data;
        out_class <= w_s2_class;
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_lt <= '0;
      cnt_gt <= '0;
      cnt_eq <= '0;
    end else if (clr_cnt) begin
      cnt_lt <= '0;
      cnt_gt <= '0;
      cnt_eq <= '0;
    end else if (w_out_fire) begin
      case (out_class)
        C_CLS_LT: cnt_lt <= sat_inc(cnt_lt);
        C_CLS_GT: cnt_gt <= sat_inc(cnt_gt);
        C_CLS_EQ: cnt_eq <= sat_inc(cnt_eq);
        default:  ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/guard_pipe.md
GUARD_PIPE -- requirements
Module: guard_pipe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 8, data/threshold/result width (>=2)
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare
- RES_LT, 0, result when data < thresh
- RES_GT, 1, result when data > thresh
- RES_EQ, 2, result otherwise
- CNT_W, 16, per-class counter width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat
- in_data  in  WIDTH  operand
- in_thresh  in  WIDTH  guard threshold, sampled with in_data
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  selected result constant
- out_class  out  2  0=LT, 1=GT, 2=EQ
- clr_cnt  in  1  synchronous counter clear
- cnt_lt/cnt_gt/cnt_eq  out  CNT_W each  saturating per-class delivered-result counts

Function
REQ-003 Guards SHALL be evaluated in order: LT first, then GT, else EQ (otherwise branch); exactly one class per beat.
REQ-004 Comparison SHALL be signed when SIGNED=1, unsigned when SIGNED=0; no widening beyond WIDTH.
REQ-005 out_data SHALL be RES_LT/RES_GT/RES_EQ truncated to WIDTH bits.
REQ-006 Pipeline SHALL have 2 register stages: S1 holds compare flags, S2 holds out_data/out_class/out_valid.
REQ-007 Input handshake fires when in_valid && in_ready; output handshake fires when out_valid && out_ready.
REQ-008 Latency SHALL be 2 cycles from input handshake to out_valid with no backpressure; throughput 1 beat/cycle.
REQ-009 Stage advances when downstream stage empty or draining same cycle; in_ready = !S1_valid || S1 advances (combinational, no dependence on in_valid).
REQ-010 While out_valid && !out_ready, out_data/out_class SHALL hold stable; no beat dropped, duplicated or reordered.
REQ-011 With out_ready held low, block SHALL absorb exactly 2 beats then deassert in_ready.
REQ-012 On output handshake, counter matching out_class SHALL increment by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-013 clr_cnt=1 SHALL zero all three counters next edge; clear wins over simultaneous increment.
REQ-014 in_data/in_thresh ignored when in_valid=0; clr_cnt does not affect pipeline contents.

Reset
REQ-015 reset=0 SHALL immediately (asynchronously) clear S1/S2 valids, out_valid=0, out_data=0, out_class=0, all counters=0.
REQ-016 Beats in flight at reset assertion SHALL be discarded; in_ready=1 during and first cycle after reset release.
REQ-017 No handshake SHALL complete while reset=0.

Verification
REQ-018 Defaults, WIDTH=8, SIGNED=1, thresh=0, out_ready=1: data 0xFB,0x00,0x05 back-to-back -> out_data 0,2,1, class 0,2,1, cycles 2,3,4 after first accept; cnt_lt=cnt_eq=cnt_gt=1.
REQ-019 SIGNED=0, thresh=0x10, data 0xF0 -> class GT, out_data 1; SIGNED=1 same stimulus -> class LT, out_data 0.
REQ-020 out_ready=0, 4 beats offered -> 2 accepted, in_ready=0, out_data stable; out_ready=1 -> remaining beats drain in order, no loss.
REQ-021 CNT_W=2, 5 LT beats delivered -> cnt_lt=3; clr_cnt asserted same cycle as a 6th LT handshake -> cnt_lt=0.
REQ-022 reset pulsed low mid-stream with 2 beats in flight -> out_valid=0 and counters=0 immediately; first post-reset beat emerges after 2 cycles.
REQ-023 Random valid/ready toggling, 10k beats vs reference model -> all results match in order; counter sum equals delivered beats.
